time_counter: RTL and testbench

Time-of-day counter driven by the one-cycle overflow strobe of the fractional divider. Holds hours, minutes and seconds as packed BCD, advances once per accepted 1 Hz strobe and ripples carries from seconds to minutes to hours. Supports field-by-field time setting from a second, faster divider strobe. Feeds the display formatter downstream.

---
 rtl/time_counter.sv | 123 ++++++++++++
 tb/tb_time_counter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// Time-of-day counter in packed BCD: HH:MM:SS with run/set modes.
// Build option: define CLOCK_12H_EN for 12-hour display with AM/PM flag (default is 24-hour).
module time_counter (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_1hz_stb,
    input  logic       i_fast_stb,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    output logic [5:0] o_hours,
    output logic [6:0] o_minutes,
    output logic [6:0] o_seconds,
    output logic       o_pm,
    output logic       o_day_stb
);

    logic [5:0] hours_q,   hours_d;
    logic [6:0] minutes_q, minutes_d;
    logic [6:0] seconds_q, seconds_d;
    logic       day_q,     day_d;
    logic       set_mode;
`ifdef CLOCK_12H_EN
    logic       pm_q, pm_d;
`endif

    // Shared by minutes and seconds: 00..59, wrapping at 0x59.
    function automatic logic [6:0] inc_sexa(input logic [6:0] v);
        if (v == 7'h59)
            return '0;
        if (v[3:0] == 4'd9)
            return {v[6:4] + 3'd1, 4'd0};
        return {v[6:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [5:0] inc_hours(input logic [5:0] v);
`ifdef CLOCK_12H_EN
        if (v == 6'h12)
            return 6'h01;
`else
        if (v == 6'h23)
            return '0;
`endif
        if (v[3:0] == 4'd9)
            return {v[5:4] + 2'd1, 4'd0};
        return {v[5:4], v[3:0] + 4'd1};
    endfunction

    assign set_mode = i_set_hours | i_set_minutes;

    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        day_d     = 1'b0;
`ifdef CLOCK_12H_EN
        pm_d      = pm_q;
`endif
        if (set_mode) begin
            seconds_d = '0;
            if (i_fast_stb) begin
                if (i_set_minutes)
                    minutes_d = inc_sexa(minutes_q);
                if (i_set_hours) begin
                    hours_d = inc_hours(hours_q);
`ifdef CLOCK_12H_EN
                    if (hours_q == 6'h11)
                        pm_d = ~pm_q;
`endif
                end
            end
        end else if (i_1hz_stb) begin
            seconds_d = inc_sexa(seconds_q);
            if (seconds_q == 7'h59) begin
                minutes_d = inc_sexa(minutes_q);
                if (minutes_q == 7'h59) begin
                    hours_d = inc_hours(hours_q);
`ifdef CLOCK_12H_EN
                    // 11 -> 12 flips AM/PM; only the PM->AM flip is a new day.
                    if (hours_q == 6'h11) begin
                        pm_d  = ~pm_q;
                        day_d = pm_q;
                    end
`else
                    day_d = (hours_q == 6'h23);
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
`ifdef CLOCK_12H_EN
            hours_q <= 6'h12;
            pm_q    <= 1'b0;
`else
            hours_q <= '0;
`endif
            minutes_q <= '0;
            seconds_q <= '0;
            day_q     <= 1'b0;
        end else begin
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            day_q     <= day_d;
`ifdef CLOCK_12H_EN
            pm_q      <= pm_d;
`endif
        end
    end

    assign o_hours   = hours_q;
    assign o_minutes = minutes_q;
    assign o_seconds = seconds_q;
    assign o_day_stb = day_q;
`ifdef CLOCK_12H_EN
    assign o_pm      = pm_q;
`else
    assign o_pm      = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter; 12-hour checks run when CLOCK_12H_EN is defined.
module tb_time_counter;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_1hz_stb = 1'b0;
    logic       i_fast_stb = 1'b0;
    logic       i_set_hours = 1'b0;
    logic       i_set_minutes = 1'b0;
    logic [5:0] o_hours;
    logic [6:0] o_minutes;
    logic [6:0] o_seconds;
    logic       o_pm;
    logic       o_day_stb;

    int n_vec = 0;
    int n_err = 0;
    int day_cnt = 0;

    time_counter dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_1hz_stb     (i_1hz_stb),
        .i_fast_stb    (i_fast_stb),
        .i_set_hours   (i_set_hours),
        .i_set_minutes (i_set_minutes),
        .o_hours       (o_hours),
        .o_minutes     (o_minutes),
        .o_seconds     (o_seconds),
        .o_pm          (o_pm),
        .o_day_stb     (o_day_stb)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (o_day_stb === 1'b1) day_cnt++;

    // One strobe cycle followed by a low cycle before the next call can raise it.
    task automatic tick(input logic hz, input logic fast);
        @(negedge clk);
        i_1hz_stb  = hz;
        i_fast_stb = fast;
        @(negedge clk);
        i_1hz_stb  = 1'b0;
        i_fast_stb = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset_n = 1'b0;
        i_set_hours = 1'b0;
        i_set_minutes = 1'b0;
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [5:0] exp_h;
`ifdef CLOCK_12H_EN
        exp_h = 6'h12;
`else
        exp_h = 6'h00;
`endif
        i_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (o_hours !== exp_h) begin n_err++; $display("FAIL reset_hours: got %h expected %h", o_hours, exp_h); end
        n_vec++; if (o_minutes !== 7'h00) begin n_err++; $display("FAIL reset_minutes: got %h expected 00", o_minutes); end
        n_vec++; if (o_seconds !== 7'h00) begin n_err++; $display("FAIL reset_seconds: got %h expected 00", o_seconds); end
        n_vec++; if (o_pm !== 1'b0) begin n_err++; $display("FAIL reset_pm: got %b expected 0", o_pm); end
        n_vec++; if (o_day_stb !== 1'b0) begin n_err++; $display("FAIL reset_day: got %b expected 0", o_day_stb); end
        i_reset_n = 1'b1;
    endtask

    task automatic test_run_minute();
        do_reset();
        day_cnt = 0;
        repeat (59) tick(1'b1, 1'b0);
        n_vec++; if (o_seconds !== 7'h59) begin n_err++; $display("FAIL run_sec59: got %h expected 59", o_seconds); end
        n_vec++; if (o_minutes !== 7'h00) begin n_err++; $display("FAIL run_min_pre: got %h expected 00", o_minutes); end
        tick(1'b1, 1'b0);
        n_vec++; if (o_seconds !== 7'h00) begin n_err++; $display("FAIL run_sec_wrap: got %h expected 00", o_seconds); end
        n_vec++; if (o_minutes !== 7'h01) begin n_err++; $display("FAIL run_min_carry: got %h expected 01", o_minutes); end
        n_vec++; if (o_hours !== 6'h00) begin n_err++; $display("FAIL run_hours: got %h expected 00", o_hours); end
        repeat (2) @(negedge clk);
        n_vec++; if (day_cnt !== 0) begin n_err++; $display("FAIL run_no_day: got %0d pulses expected 0", day_cnt); end
    endtask

    task automatic test_set_minutes();
        int bad = 0;
        do_reset();
        repeat (5) tick(1'b1, 1'b0);
        @(negedge clk);
        i_set_minutes = 1'b1;
        @(negedge clk);
        n_vec++; if (o_seconds !== 7'h00) begin n_err++; $display("FAIL set_sec_clear: got %h expected 00", o_seconds); end
        for (int i = 1; i <= 61; i++) begin
            tick(1'b0, 1'b1);
            if (i % 10 == 0) tick(1'b1, 1'b0);
            if (o_seconds !== 7'h00) bad++;
            if (i == 60) begin
                n_vec++; if (o_minutes !== 7'h00) begin n_err++; $display("FAIL set_min_wrap: got %h expected 00", o_minutes); end
            end
        end
        n_vec++; if (o_minutes !== 7'h01) begin n_err++; $display("FAIL set_min_61: got %h expected 01", o_minutes); end
        n_vec++; if (o_hours !== 6'h00) begin n_err++; $display("FAIL set_min_no_carry: got %h expected 00", o_hours); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL set_sec_held: got %0d nonzero samples expected 0", bad); end
        i_set_minutes = 1'b0;
    endtask

    task automatic test_day_wrap();
        do_reset();
        @(negedge clk);
        i_set_hours = 1'b1;
        repeat (23) tick(1'b0, 1'b1);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        repeat (59) tick(1'b0, 1'b1);
        i_set_minutes = 1'b0;
        repeat (58) tick(1'b1, 1'b0);
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== {6'h23, 7'h59, 7'h58}) begin n_err++;
            $display("FAIL wrap_set_235958: got %h:%h:%h expected 23:59:58", o_hours, o_minutes, o_seconds); end
        day_cnt = 0;
        tick(1'b1, 1'b0);
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== {6'h23, 7'h59, 7'h59}) begin n_err++;
            $display("FAIL wrap_235959: got %h:%h:%h expected 23:59:59", o_hours, o_minutes, o_seconds); end
        n_vec++; if (o_day_stb !== 1'b0) begin n_err++; $display("FAIL wrap_day_early: got %b expected 0", o_day_stb); end
        tick(1'b1, 1'b0);
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== 20'h0) begin n_err++;
            $display("FAIL wrap_000000: got %h:%h:%h expected 00:00:00", o_hours, o_minutes, o_seconds); end
        n_vec++; if (o_day_stb !== 1'b1) begin n_err++; $display("FAIL wrap_day_pulse: got %b expected 1", o_day_stb); end
        @(negedge clk);
        n_vec++; if (o_day_stb !== 1'b0) begin n_err++; $display("FAIL wrap_day_drop: got %b expected 0", o_day_stb); end
        repeat (2) @(negedge clk);
        n_vec++; if (day_cnt !== 1) begin n_err++; $display("FAIL wrap_day_count: got %0d expected 1", day_cnt); end
    endtask

    task automatic test_both_set();
        do_reset();
        @(negedge clk);
        i_set_hours = 1'b1;
        repeat (9) tick(1'b0, 1'b1);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        repeat (9) tick(1'b0, 1'b1);
        i_set_hours = 1'b1;
        tick(1'b0, 1'b1);
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== {6'h10, 7'h10, 7'h00}) begin n_err++;
            $display("FAIL both_set: got %h:%h:%h expected 10:10:00", o_hours, o_minutes, o_seconds); end
        @(negedge clk);
        i_reset_n = 1'b0;
        i_fast_stb = 1'b1;
        @(negedge clk);
        i_fast_stb = 1'b0;
        i_reset_n = 1'b1;
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== 20'h0) begin n_err++;
            $display("FAIL reset_prio: got %h:%h:%h expected 00:00:00", o_hours, o_minutes, o_seconds); end
        n_vec++; if (o_pm !== 1'b0) begin n_err++; $display("FAIL reset_prio_pm: got %b expected 0", o_pm); end
        i_set_hours = 1'b0;
        i_set_minutes = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(1'b1, 1'b1);
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== {6'h00, 7'h00, 7'h01}) begin n_err++;
            $display("FAIL simul_run: got %h:%h:%h expected 00:00:01", o_hours, o_minutes, o_seconds); end
        @(negedge clk);
        i_set_hours = 1'b1;
        tick(1'b1, 1'b1);
        n_vec++; if ({o_hours, o_minutes, o_seconds} !== {6'h01, 7'h00, 7'h00}) begin n_err++;
            $display("FAIL simul_set: got %h:%h:%h expected 01:00:00", o_hours, o_minutes, o_seconds); end
        i_set_hours = 1'b0;
        repeat (2) tick(1'b1, 1'b0);
        n_vec++; if (o_seconds !== 7'h02) begin n_err++; $display("FAIL resume_run: got %h expected 02", o_seconds); end
    endtask

`ifdef CLOCK_12H_EN
    task automatic test_12h();
        int h;
        logic [5:0] exp_h;
        logic exp_pm;
        do_reset();
        @(negedge clk);
        i_set_hours = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick(1'b0, 1'b1);
            h = ((k - 1) % 12) + 1;
            exp_h = {2'(h / 10), 4'(h % 10)};
            exp_pm = (k >= 12) && (k < 24);
            n_vec++; if ({o_hours, o_pm} !== {exp_h, exp_pm}) begin n_err++;
                $display("FAIL h12_step%0d: got %h pm=%b expected %h pm=%b", k, o_hours, o_pm, exp_h, exp_pm); end
        end
        repeat (23) tick(1'b0, 1'b1);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        repeat (59) tick(1'b0, 1'b1);
        i_set_minutes = 1'b0;
        repeat (59) tick(1'b1, 1'b0);
        n_vec++; if ({o_hours, o_minutes, o_seconds, o_pm} !== {6'h11, 7'h59, 7'h59, 1'b1}) begin n_err++;
            $display("FAIL h12_115959pm: got %h:%h:%h pm=%b expected 11:59:59 pm=1", o_hours, o_minutes, o_seconds, o_pm); end
        tick(1'b1, 1'b0);
        n_vec++; if ({o_hours, o_minutes, o_seconds, o_pm} !== {6'h12, 7'h00, 7'h00, 1'b0}) begin n_err++;
            $display("FAIL h12_midnight: got %h:%h:%h pm=%b expected 12:00:00 pm=0", o_hours, o_minutes, o_seconds, o_pm); end
        n_vec++; if (o_day_stb !== 1'b1) begin n_err++; $display("FAIL h12_day_pulse: got %b expected 1", o_day_stb); end
        @(negedge clk);
        n_vec++; if (o_day_stb !== 1'b0) begin n_err++; $display("FAIL h12_day_drop: got %b expected 0", o_day_stb); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CLOCK_12H_EN
        test_12h();
`else
        test_run_minute();
        test_set_minutes();
        test_day_wrap();
        test_both_set();
        test_simultaneous();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
